// File: rtl/load_store_unit.sv
// load_store_unit: sequences word/half/byte loads and stores onto a word-wide data memory,
// using read-modify-write for sub-word stores.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3, OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
  typedef enum logic [2:0] {IDLE, LOAD, RMW, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_misalign;
  logic        w_accept, w_misalign, w_byte;
  logic [1:0]  w_lane;
  logic [4:0]  w_sh;
  logic [15:0] w_lo;
  logic [31:0] w_mask, w_merge, w_load;
  assign w_accept   = req_valid && r_state == IDLE;
  assign w_misalign = (req_op == OP_LW || req_op == OP_SW) ? req_addr[1:0] != 2'b00 :
                      (req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) ? req_addr[0] : 1'b0;
  // Byte ops select lane addr[1:0]; halfword ops select lane {addr[1],0}.
  assign w_byte  = r_op == OP_LB || r_op == OP_LBU || r_op == OP_SB;
  assign w_lane  = w_byte ? r_addr[1:0] : {r_addr[1], 1'b0};
  assign w_sh    = {w_lane, 3'b000};
  assign w_lo    = 16'(mem_rdata >> w_sh);
  assign w_mask  = (w_byte ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
  assign w_merge = (mem_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);
  assign w_load  = r_op == OP_LH  ? {{16{w_lo[15]}}, w_lo} :
                   r_op == OP_LHU ? {16'h0000, w_lo} :
                   r_op == OP_LB  ? {{24{w_lo[7]}}, w_lo[7:0]} :
                   r_op == OP_LBU ? {24'h000000, w_lo[7:0]} : mem_rdata;
  assign resp_rdata = r_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_op       <= req_op;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_rdata    <= '0;
      r_misalign <= w_misalign;
    end else if (r_state == LOAD) begin
      r_rdata    <= w_load;
    end else if (r_state == RMW) begin
      r_wdata    <= w_merge;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_misalign ? RESP : req_op < OP_SW ? LOAD : req_op == OP_SW ? WRITE : RMW;
      LOAD:    w_next = RESP;
      RMW:     w_next = WRITE;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready     = r_state == IDLE;
    stall         = r_state != IDLE;
    resp_valid    = r_state == RESP;
    resp_misalign = r_state == RESP && r_misalign;
    mem_we        = r_state == WRITE;
    mem_addr      = (r_state == LOAD || r_state == RMW || r_state == WRITE) ? {r_addr[31:2], 2'b00} : '0;
    mem_wdata     = r_state == WRITE ? r_wdata : '0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_misalign, stall, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic [7:0]  rb [0:1023];
  int checks = 0, errors = 0;

  load_store_unit dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign), .stall(stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  function automatic int size_of(input logic [2:0] op);
    return (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
  endfunction
  function automatic logic ref_mis(input logic [2:0] op, input logic [31:0] a);
    return (int'(a[9:0]) % size_of(op)) != 0;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    longint v = 0;
    int base = int'(a[9:0]);
    for (int i = 0; i < size_of(op); i++) v = v + (longint'(rb[base + i]) << (8 * i));
    if (op == 3'd1 && v >= 32768) v = v - 65536;
    if (op == 3'd3 && v >= 128) v = v - 256;
    return 32'(v);
  endfunction
  function automatic logic [31:0] ref_word(input int i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction
  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    int base = int'(a[9:0]);
    for (int i = 0; i < size_of(op); i++) rb[base + i] = w[8*i +: 8];
  endtask
  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    mem[a[9:2]] = v;
    for (int k = 0; k < 4; k++) rb[4 * int'(a[9:2]) + k] = v[8*k +: 8];
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                       output int lat, output logic [31:0] rd, output logic mis,
                       output int wes, output int we_k, output logic [31:0] we_d);
    int guard = 0;
    lat = 0; rd = '0; mis = 1'b0; wes = 0; we_k = 0; we_d = '0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_we) begin wes++; we_k = k; we_d = mem_wdata; end
      if (resp_valid) begin lat = k; rd = resp_rdata; mis = resp_misalign; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", resp_misalign); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_loads;
    logic [2:0]  ops  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
    logic [31:0] adrs [5] = '{32'h10010005, 32'h10010005, 32'h10010006, 32'h10010006, 32'h10010004};
    logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
    int lat, wes, we_k;
    logic [31:0] rd, we_d;
    logic mis;
    set_word(32'h10010004, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], adrs[i], $urandom, lat, rd, mis, wes, we_k, we_d);
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency got %0d want 2", i, lat); end
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, exps[i]); end
      checks++; if (mis !== 1'b0 || wes != 0) begin errors++; $display("FAIL load%0d_side got mis=%b we=%0d want 0/0", i, mis, wes); end
    end
  endtask

  task automatic test_byte_store;
    int lat, wes, we_k;
    logic [31:0] rd, we_d;
    logic mis;
    do_op(3'd7, 32'h10010007, 32'h12345677, lat, rd, mis, wes, we_k, we_d);
    ref_store(3'd7, 32'h10010007, 32'h12345677);
    checks++; if (wes != 1 || we_k != 2) begin errors++; $display("FAIL sb_we got count=%0d cycle=%0d want 1 at 2", wes, we_k); end
    checks++; if (we_d !== 32'h7799AABB) begin errors++; $display("FAIL sb_wdata got %h want 7799aabb", we_d); end
    checks++; if (lat != 3 || mis !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp got lat=%0d mis=%b rd=%h want 3/0/0", lat, mis, rd); end
    do_op(3'd0, 32'h10010004, 32'h0, lat, rd, mis, wes, we_k, we_d);
    checks++; if (rd !== 32'h7799AABB || lat != 2) begin errors++; $display("FAIL sb_readback got %h lat=%0d want 7799aabb lat=2", rd, lat); end
  endtask

  task automatic test_misalign;
    logic [2:0]  ops  [2] = '{3'd0, 3'd6};
    logic [31:0] adrs [2] = '{32'h10010006, 32'h10010001};
    int lat, wes, we_k;
    logic [31:0] rd, we_d;
    logic mis;
    for (int i = 0; i < 2; i++) begin
      do_op(ops[i], adrs[i], 32'hA5A5A5A5, lat, rd, mis, wes, we_k, we_d);
      checks++; if (lat != 1 || mis !== 1'b1) begin errors++; $display("FAIL mis%0d_resp got lat=%0d mis=%b want 1/1", i, lat, mis); end
      checks++; if (wes != 0 || rd !== 32'h0) begin errors++; $display("FAIL mis%0d_side got we=%0d rd=%h want 0/0", i, wes, rd); end
      checks++; if (mem[0] !== ref_word(0)) begin errors++; $display("FAIL mis%0d_mem got %h want %h", i, mem[0], ref_word(0)); end
    end
  endtask

  task automatic test_back_to_back;
    int guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h10010008; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_op = 3'd0; req_wdata = 32'h0;
    ref_store(3'd5, 32'h10010008, 32'hDEADBEEF);
    checks++; if (req_ready !== 1'b0 || stall !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL b2b_write got rdy=%b stall=%b we=%b want 0/1/1", req_ready, stall, mem_we); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_resp got v=%b rdy=%b stall=%b want 1/0/1", resp_valid, req_ready, stall); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%b stall=%b want 1/0", req_ready, stall); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (stall !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_load got stall=%b v=%b want 1/0", stall, resp_valid); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got v=%b rd=%h want 1/deadbeef", resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_during_write;
    int guard = 0, lat, wes, we_k;
    logic [31:0] rd, we_d;
    logic mis;
    set_word(32'h1001000C, 32'hCAFEF00D);
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h1001000C; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstw_we_before got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstw_mem_port got we=%b wd=%h a=%h want 0/0/0", mem_we, mem_wdata, mem_addr); end
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_ctrl got rdy=%b stall=%b v=%b want 1/0/0", req_ready, stall, resp_valid); end
    @(posedge clk); #1;
    checks++; if (mem[3] !== 32'hCAFEF00D) begin errors++; $display("FAIL rstw_mem got %h want cafef00d", mem[3]); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_release got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
    do_op(3'd0, 32'h1001000C, 32'h0, lat, rd, mis, wes, we_k, we_d);
    checks++; if (lat != 2 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstw_readback got lat=%0d rd=%h want 2/cafef00d", lat, rd); end
  endtask

  task automatic test_random;
    int lat, wes, we_k, exp_lat, exp_wes;
    logic [31:0] rd, we_d, a, w, exp_rd;
    logic [2:0] op;
    logic mis, exp_mis;
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 32'h10010000 + 32'($urandom_range(0, 255));
      w = $urandom;
      exp_mis = ref_mis(op, a);
      exp_lat = exp_mis ? 1 : (op == 3'd6 || op == 3'd7) ? 3 : 2;
      exp_rd  = (!exp_mis && op < 3'd5) ? ref_load(op, a) : 32'h0;
      exp_wes = (!exp_mis && op >= 3'd5) ? 1 : 0;
      do_op(op, a, w, lat, rd, mis, wes, we_k, we_d);
      checks++; if (lat != exp_lat || mis !== exp_mis || rd !== exp_rd || wes != exp_wes)
        begin errors++; $display("FAIL rand%0d op=%0d a=%h got lat=%0d mis=%b rd=%h we=%0d want %0d/%b/%h/%0d", n, op, a, lat, mis, rd, wes, exp_lat, exp_mis, exp_rd, exp_wes); end
      if (exp_wes == 1) begin
        ref_store(op, a, w);
        checks++; if (we_d !== ref_word(int'(a[9:2]))) begin errors++; $display("FAIL rand%0d_wdata got %h want %h", n, we_d, ref_word(int'(a[9:2]))); end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      checks++; if (mem[i] !== ref_word(i)) begin errors++; $display("FAIL mem_word%0d got %h want %h", i, mem[i], ref_word(i)); end
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      for (int k = 0; k < 4; k++) rb[4*i+k] = v[8*k +: 8];
    end
    test_reset;
    test_loads;
    test_byte_store;
    test_misalign;
    test_back_to_back;
    test_reset_during_write;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req_valid  input  1  pipeline presents a memory operation.
REQ-004 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-005 SHALL have port req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 SHALL have port req_addr  input  32  byte address, passed through unmodified apart from word alignment.
REQ-007 SHALL have port req_wdata  input  32  store data; SH uses [15:0], SB uses [7:0].
REQ-008 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-009 SHALL have port resp_rdata  output  32  extended load result.
REQ-010 SHALL have port resp_misalign  output  1  qualifies resp_valid; access aborted.
REQ-011 SHALL have port stall  output  1  pipeline hold.
REQ-012 SHALL have ports mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32), forming the data-memory port; the memory reads combinationally, little-endian, and writes whole words on the clock edge.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RMW, WRITE and RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, latching op, addr and wdata.
REQ-015 SHALL route an accepted request as follows: misaligned -> RESP; load -> LOAD; SW -> WRITE; SH/SB -> RMW.
REQ-016 SHALL treat an access as misaligned when it is a word access with addr[1:0]!=0, or a halfword access with addr[0]!=0; byte accesses are never misaligned.
REQ-017 SHALL drive mem_addr={addr[31:2],2'b00} from the latched address in LOAD, RMW and WRITE, and 0 otherwise.
REQ-018 SHALL assert mem_we only in WRITE, for exactly one cycle per store; mem_wdata is 0 outside WRITE.
REQ-019 SHALL, in LOAD, register resp_rdata from mem_rdata as follows: LW = word; LH/LHU = half at bits [addr[1]*16 +: 16]; LB/LBU = byte at [addr[1:0]*8 +: 8]; sign-extend for LH/LB, zero-extend for LHU/LBU.
REQ-020 SHALL, in RMW, register a merge word equal to mem_rdata with the addressed byte or half lane replaced by store data; WRITE then drives the merged word; SW drives req_wdata unmodified.
REQ-021 SHALL assert resp_valid in RESP for one cycle, then return to IDLE.
REQ-022 SHALL drive resp_rdata=0 on store and misaligned responses.
REQ-023 SHALL drive resp_misalign=1 only alongside resp_valid for an aborted access, and never touch memory for it.
REQ-024 SHALL produce resp_valid with these latencies after the acceptance cycle: misaligned +1; load +2; SW +2; SH/SB +3.
REQ-025 SHALL drive stall=1 whenever state!=IDLE, and stall=0 in IDLE.
REQ-026 SHALL ignore req_valid while busy; the request must be held and is accepted in the next IDLE cycle.
REQ-027 SHALL allow a back-to-back request to be accepted in the cycle immediately after RESP.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, req_ready=1, resp_valid=0, resp_misalign=0, resp_rdata=0, stall=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-029 SHALL, when reset asserts mid-operation (including during WRITE before the edge), discard the operation and perform no memory write and no response.
REQ-030 SHALL accept a request on the first clock edge after rst_n deasserts.

Verification
REQ-031 SHALL cover byte loads: word at 0x10010004 = 0x8899AABB; LB at 0x10010005 -> resp_rdata 0xFFFFFFAA at accept+2; LBU -> 0x000000AA.
REQ-032 SHALL cover halfword loads on the same word: LH at 0x10010006 -> 0xFFFF8899; LHU -> 0x00008899; LW at 0x10010004 -> 0x8899AABB.
REQ-033 SHALL cover a byte store: SB at 0x10010007 with wdata 0x12345677 -> mem_we high exactly at accept+2 with mem_wdata 0x7799AABB, resp_valid at accept+3; a following LW returns 0x7799AABB.
REQ-034 SHALL cover misalignment: LW at 0x10010006 and SH at 0x10010001 -> resp_valid with resp_misalign=1 at accept+1, mem_we never asserted, memory unchanged.
REQ-035 SHALL cover back-to-back traffic: SW 0xDEADBEEF at 0x10010008, then LW at the same address with req_valid held -> req_ready=0 and stall=1 while busy, LW accepted the cycle after RESP, returns 0xDEADBEEF.
REQ-036 SHALL cover reset during WRITE of SW 0x11111111: rst_n low -> mem_we drops combinationally, memory keeps its prior value, no resp_valid, req_ready=1 after release.
